register_bank: RTL and testbench
================================

Name: register_bank

Overview:
- MIPS general-purpose register file consumed by the decode stage; feeds rs/rt operands to execute and accepts write-back.
- Register 0 is the hardwired-zero register: reads return 0 and writes are discarded.
- Registers 1..2^a-1 are n-bit enabled registers.
- Adds a per-register busy scoreboard (set at issue, cleared at write-back) so decode can stall on a pending destination.

Parameters:
- n, 32, data width of every register.
- a, 5, address width; register count = 2^a.
- BYPASS, 1, 1 = write-through forwarding of the same-cycle write-back to the read ports; 0 = read returns the pre-write value.

Ports:
- clk_port  input  1  clock; all state updates on the rising edge.
- rst_port  input  1  reset, asynchronous, active-low.
- rs_addr_port  input  a  read address A.
- rt_addr_port  input  a  read address B.
- rs_data_port  output  n  read data A (combinational).
- rt_data_port  output  n  read data B (combinational).
- wr_en_port  input  1  write-back enable.
- wr_addr_port  input  a  write-back address.
- wr_data_port  input  n  write-back data.
- issue_en_port  input  1  an instruction with a destination issues this cycle.
- issue_addr_port  input  a  destination of the issuing instruction.
- stall_port  output  1  high when a read or issue target is busy.

Behaviour:
- Reset (rst_port=0, asynchronous):
  - Clears all registers to 0 and all busy bits to 0.
  - While reset is asserted, reads return 0 and stall_port=0.
  - On deassertion, operation resumes at the next rising edge.
- Reads:
  - Combinational, zero-latency.
  - Address 0 always reads 0, regardless of any write or bypass.
- Write:
  - On a rising edge with wr_en_port=1 and wr_addr_port≠0, reg[wr_addr_port] <= wr_data_port.
  - Writes to address 0 are ignored and do not change any busy bit.
- Bypass (BYPASS=1):
  - If wr_en_port=1, wr_addr_port≠0 and the read address equals wr_addr_port, the read port returns wr_data_port in the same cycle.
  - Each read port is bypassed independently.
- Scoreboard, per register busy[i] (busy[0] is constant 0):
  - Set when issue_en_port=1 and issue_addr_port=i≠0.
  - Cleared when wr_en_port=1 and wr_addr_port=i.
  - If set and clear hit the same register in the same cycle, set wins: the new producer is still outstanding, so busy stays 1.
  - Set and clear on different registers both take effect.
- stall_port (combinational) is 1 if any of the following holds:
  - busy[rs_addr_port]=1 and that register is not being written this cycle.
  - busy[rt_addr_port]=1 and that register is not being written this cycle.
  - issue_en_port=1 and busy[issue_addr_port]=1 and that register is not being written this cycle (WAW).
  - With BYPASS=0, a busy register being written this cycle still stalls.
- Stall ownership: while stall_port=1 the issue is not accepted, so the scoreboard ignores issue_en_port that cycle. The upstream stage holds its request.
- No arithmetic; data passes through unmodified at width n.

Test Plan:
- Reset then read: drive rst_port=0 mid-run after writing reg5=0xDEADBEEF, release -> rs_data_port(5)=0, stall_port=0.
- Zero register: write 0x12345678 to addr 0, read addr 0 on both ports -> 0; busy[0] never set, even with issue_addr_port=0.
- Write/read with bypass (BYPASS=1):
  - Same cycle wr_addr=7, wr_data=0xA5A5A5A5, rs_addr=7 -> rs_data_port=0xA5A5A5A5 that cycle.
  - With BYPASS=0 -> old value that cycle, new value next cycle.
- Scoreboard RAW:
  - Issue dest 3; next cycle rs_addr=3 -> stall_port=1.
  - Write-back addr 3 in a later cycle -> stall_port=0 that cycle (BYPASS=1) and busy[3]=0 after the edge.
- Simultaneous set/clear: wr_en on addr 9 and issue_en dest 9 in the same cycle, with busy[9] previously 1 -> busy[9] stays 1; the following read of rt_addr=9 stalls.
- WAW: busy[4]=1, issue_en dest 4 with no write-back -> stall_port=1, busy unchanged; after write-back to 4, the re-issue is accepted and busy[4]=1.

Source files
------------

// File: rtl/register_bank.sv
// MIPS general-purpose register file with hardwired-zero r0, optional write-through
// forwarding, and a per-register busy scoreboard that drives the decode stall.
module register_bank #(
    parameter int n      = 32,
    parameter int a      = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic         clk_port,
    input  logic         rst_port,
    input  logic [a-1:0] rs_addr_port,
    input  logic [a-1:0] rt_addr_port,
    output logic [n-1:0] rs_data_port,
    output logic [n-1:0] rt_data_port,
    input  logic         wr_en_port,
    input  logic [a-1:0] wr_addr_port,
    input  logic [n-1:0] wr_data_port,
    input  logic         issue_en_port,
    input  logic [a-1:0] issue_addr_port,
    output logic         stall_port
);

    localparam int NREG = 1 << a;

    logic [n-1:0]    regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    logic wr_valid;
    logic rs_pending;
    logic rt_pending;
    logic issue_pending;
    logic issue_accept;

    assign wr_valid = wr_en_port && (wr_addr_port != '0);

    always_comb begin
        rs_data_port = '0;
        rt_data_port = '0;
        if (rst_port) begin
            if (rs_addr_port != '0) begin
                rs_data_port = (BYPASS && wr_valid && (wr_addr_port == rs_addr_port))
                             ? wr_data_port : regs[rs_addr_port];
            end
            if (rt_addr_port != '0) begin
                rt_data_port = (BYPASS && wr_valid && (wr_addr_port == rt_addr_port))
                             ? wr_data_port : regs[rt_addr_port];
            end
        end
    end

    // A busy register being written this cycle is only resolved if forwarding exists.
    always_comb begin
        rs_pending    = busy[rs_addr_port]
                        && !(BYPASS && wr_valid && (wr_addr_port == rs_addr_port));
        rt_pending    = busy[rt_addr_port]
                        && !(BYPASS && wr_valid && (wr_addr_port == rt_addr_port));
        issue_pending = issue_en_port && busy[issue_addr_port]
                        && !(BYPASS && wr_valid && (wr_addr_port == issue_addr_port));
        stall_port    = rst_port && (rs_pending || rt_pending || issue_pending);
        issue_accept  = issue_en_port && !stall_port && (issue_addr_port != '0);
    end

    // Clear first, then set, so a new producer on the written register stays outstanding.
    always_comb begin
        busy_next = busy;
        if (wr_valid) begin
            busy_next[wr_addr_port] = 1'b0;
        end
        if (issue_accept) begin
            busy_next[issue_addr_port] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    always_ff @(posedge clk_port or negedge rst_port) begin
        if (!rst_port) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[wr_addr_port] <= wr_data_port;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: directed vector table, reset sequences and randomized traffic
// against a reference model, covering both the forwarding and non-forwarding variants.
module tb_register_bank;

    localparam int N  = 32;
    localparam int A  = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [A-1:0] rs_addr, rt_addr, wr_addr, issue_addr;
    logic         wr_en, issue_en;
    logic [N-1:0] wr_data;
    logic [N-1:0] rs_b, rt_b, rs_nb, rt_nb;
    logic         stall_b, stall_nb;

    register_bank #(.n(N), .a(A), .BYPASS(1'b1)) dut (
        .clk_port(clk), .rst_port(rst_n),
        .rs_addr_port(rs_addr), .rt_addr_port(rt_addr),
        .rs_data_port(rs_b), .rt_data_port(rt_b),
        .wr_en_port(wr_en), .wr_addr_port(wr_addr), .wr_data_port(wr_data),
        .issue_en_port(issue_en), .issue_addr_port(issue_addr),
        .stall_port(stall_b)
    );

    register_bank #(.n(N), .a(A), .BYPASS(1'b0)) dut_nb (
        .clk_port(clk), .rst_port(rst_n),
        .rs_addr_port(rs_addr), .rt_addr_port(rt_addr),
        .rs_data_port(rs_nb), .rt_data_port(rt_nb),
        .wr_en_port(wr_en), .wr_addr_port(wr_addr), .wr_data_port(wr_data),
        .issue_en_port(issue_en), .issue_addr_port(issue_addr),
        .stall_port(stall_nb)
    );

    // Reference state: one register array, one scoreboard per variant (index = bypass flag).
    logic [N-1:0] m_regs [NR];
    bit           m_busy [2][NR];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [A-1:0] rs, rt;
        logic         we;
        logic [A-1:0] wa;
        logic [N-1:0] wd;
        logic         ie;
        logic [A-1:0] ia;
        logic [N-1:0] e_rs, e_rt;
        logic         e_st;
        logic [N-1:0] e_rs_nb;
    } vec_t;

    vec_t tbl [16];

    function automatic logic [N-1:0] m_read(input logic [A-1:0] addr, input bit byp);
        if (!rst_n || addr == 0) return '0;
        if (byp && wr_en && wr_addr == addr) return wr_data;
        return m_regs[addr];
    endfunction

    function automatic bit m_pending(input logic [A-1:0] x, input bit byp);
        return m_busy[byp][x] && !(byp && wr_en && wr_addr == x && x != 0);
    endfunction

    function automatic bit m_stall(input bit byp);
        if (!rst_n) return 1'b0;
        return m_pending(rs_addr, byp) || m_pending(rt_addr, byp)
               || (issue_en && m_pending(issue_addr, byp));
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i]    = '0;
            m_busy[0][i] = 1'b0;
            m_busy[1][i] = 1'b0;
        end
    endtask

    task automatic m_edge(input bit st0, input bit st1);
        if (!rst_n) return;
        if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
        for (int b = 0; b < 2; b++) begin
            if (wr_en) m_busy[b][wr_addr] = 1'b0;
            if (issue_en && issue_addr != 0 && !((b == 1) ? st1 : st0))
                m_busy[b][issue_addr] = 1'b1;
        end
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        rs_addr = '0; rt_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0;
    endtask

    task automatic model_checks(input string tag);
        check({tag, " rs"},       rs_b,     m_read(rs_addr, 1'b1));
        check({tag, " rt"},       rt_b,     m_read(rt_addr, 1'b1));
        check({tag, " stall"},    {31'b0, stall_b},  {31'b0, m_stall(1'b1)});
        check({tag, " rs_nb"},    rs_nb,    m_read(rs_addr, 1'b0));
        check({tag, " rt_nb"},    rt_nb,    m_read(rt_addr, 1'b0));
        check({tag, " stall_nb"}, {31'b0, stall_nb}, {31'b0, m_stall(1'b0)});
    endtask

    // Called at negedge+1 with inputs applied; advances model and DUT by one clock.
    task automatic tick();
        bit s0, s1;
        s0 = m_stall(1'b0);
        s1 = m_stall(1'b1);
        @(posedge clk);
        m_edge(s0, s1);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{5'd7, 5'd0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'hA5A5A5A5, 32'h0, 1'b0, 32'h0};
        tbl[1]  = '{5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5};
        tbl[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[3]  = '{5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[4]  = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0};
        tbl[5]  = '{5'd3, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h33, 32'h0, 1'b0, 32'h0};
        tbl[6]  = '{5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h33, 32'h0, 1'b0, 32'h33};
        tbl[7]  = '{5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[8]  = '{5'd0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[9]  = '{5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h99, 1'b1, 32'h0};
        tbl[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[11] = '{5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h0, 32'h0, 1'b1, 32'h0};
        tbl[12] = '{5'd0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4, 32'h0, 32'h0, 1'b0, 32'h0};
        tbl[13] = '{5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h44, 32'h0, 1'b1, 32'h44};
        tbl[14] = '{5'd4, 5'd0, 1'b1, 5'd4, 32'h45, 1'b0, 5'd0, 32'h45, 32'h0, 1'b0, 32'h44};
        tbl[15] = '{5'd0, 5'd9, 1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'h0, 32'h90, 1'b0, 32'h0};

        // Power-on reset with a write and busy target presented: reads must still be 0.
        idle();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rs_addr = 5'd7; rt_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hFFFF0000;
        issue_en = 1'b1; issue_addr = 5'd7;
        #1;
        check("reset rs", rs_b, 32'h0);
        check("reset rt", rt_b, 32'h0);
        check("reset stall", {31'b0, stall_b}, 32'h0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;

        for (int i = 0; i < 16; i++) begin
            rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            issue_en = tbl[i].ie; issue_addr = tbl[i].ia;
            #1;
            check($sformatf("vec%0d rs", i),    rs_b,  tbl[i].e_rs);
            check($sformatf("vec%0d rt", i),    rt_b,  tbl[i].e_rt);
            check($sformatf("vec%0d stall", i), {31'b0, stall_b}, {31'b0, tbl[i].e_st});
            check($sformatf("vec%0d rs_nb", i), rs_nb, tbl[i].e_rs_nb);
            model_checks($sformatf("vec%0d model", i));
            tick();
        end

        // Mid-run asynchronous reset after loading reg5 and marking reg6 busy.
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1; tick();
        idle();
        issue_en = 1'b1; issue_addr = 5'd6;
        #1; tick();
        idle();
        rs_addr = 5'd5; rt_addr = 5'd6;
        #1;
        check("pre-reset rs5", rs_b, 32'hDEADBEEF);
        check("pre-reset stall", {31'b0, stall_b}, 32'h1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h11111111;
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        check("async reset rs5", rs_b, 32'h0);
        check("async reset rs5_nb", rs_nb, 32'h0);
        check("async reset stall", {31'b0, stall_b}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        rs_addr = 5'd5; rt_addr = 5'd6;
        #1;
        check("post-reset rs5", rs_b, 32'h0);
        check("post-reset stall", {31'b0, stall_b}, 32'h0);
        model_checks("post-reset");
        tick();

        // Randomized traffic; addresses mostly in a small window to force collisions.
        for (int c = 0; c < 400; c++) begin
            rs_addr    = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 7));
            rt_addr    = ($urandom_range(0, 3) == 0) ? A'($urandom) : A'($urandom_range(0, 7));
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = A'($urandom_range(0, 7));
            wr_data    = $urandom;
            issue_en   = $urandom_range(0, 1) == 1;
            issue_addr = A'($urandom_range(0, 7));
            #1;
            model_checks($sformatf("rand%0d", c));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
